// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared types, funct3 encodings and legality check for the MEM-stage LSU
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 255;

  // Unsigned sizes are load-only; anything outside the five encodings is illegal.
  function automatic logic access_fault(input logic [2:0] f3, input logic is_store,
                                        input logic [1:0] off);
    case (f3)
      F3_B:    access_fault = 1'b0;
      F3_H:    access_fault = off[0];
      F3_W:    access_fault = |off;
      F3_BU:   access_fault = is_store;
      F3_HU:   access_fault = is_store | off[0];
      default: access_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication/byte enables and load extraction/extension
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      2'b00: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << st_off;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = ld_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   ld_data = {24'd0, shifted[7:0]};
      F3_HU:   ld_data = {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit driving the req/gnt/rvalid data-memory port
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallMemM,
  output logic [31:0] ReadDataM,
  output logic        LoadValidM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err
);

  lsu_state_t  state, state_n;
  logic [7:0]  wd_cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] ld_data;
  logic        access, fault, wd_hit, stall, busy;

  lsu_align u_align (
    .st_size   (funct3M[1:0]),
    .st_off    (ALUResultM[1:0]),
    .st_data   (WriteDataM),
    .st_be     (be_n),
    .st_wdata  (wdata_n),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .ld_rdata  (dmem_rdata),
    .ld_data   (ld_data)
  );

  assign access    = MemReadM | MemWriteM;
  assign fault     = access_fault(funct3M, MemWriteM, ALUResultM[1:0]);
  assign busy      = (state == REQ) || (state == RESP);
  assign wd_hit    = busy && (wd_cnt == 8'(TIMEOUT - 1));
  assign dmem_req  = (state == REQ);
  assign MisalignM = (state == IDLE) && access && fault;
  assign StallMemM = stall & ~reset;

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    case (state)
      IDLE: if (access && !fault) begin
        stall   = 1'b1;
        state_n = REQ;
      end
      // Watchdog beats a late grant: the request is abandoned, not accepted.
      REQ: begin
        stall = 1'b1;
        if (wd_hit)        state_n = DONE;
        else if (dmem_gnt) state_n = RESP;
      end
      RESP: begin
        stall = 1'b1;
        if (dmem_rvalid || wd_hit) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wd_cnt     <= 8'd0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'd0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      ReadDataM  <= 32'd0;
      LoadValidM <= 1'b0;
      BusErrM    <= 1'b0;
    end else begin
      state      <= state_n;
      LoadValidM <= 1'b0;
      BusErrM    <= 1'b0;
      if (state == IDLE && state_n == REQ) begin
        wd_cnt     <= 8'd0;
        f3_q       <= funct3M;
        off_q      <= ALUResultM[1:0];
        dmem_we    <= MemWriteM;
        dmem_be    <= MemWriteM ? be_n : 4'b1111;
        dmem_addr  <= {ALUResultM[31:2], 2'b00};
        dmem_wdata <= MemWriteM ? wdata_n : 32'd0;
      end else if (busy) begin
        wd_cnt <= wd_cnt + 8'd1;
      end
      if (state == RESP && dmem_rvalid) begin
        LoadValidM <= 1'b1;
        BusErrM    <= dmem_err;
        if (!dmem_we) ReadDataM <= dmem_err ? 32'd0 : ld_data;
      end else if (wd_hit) begin
        LoadValidM <= 1'b1;
        BusErrM    <= 1'b1;
        ReadDataM  <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallMemM, LoadValidM, MisalignM, BusErrM;
  logic [31:0] ReadDataM;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid, dmem_err;
  logic [31:0] dmem_rdata;

  logic        t_stall, t_lv, t_mis, t_berr, t_req, t_we;
  logic [31:0] t_rd, t_addr, t_wdata;
  logic [3:0]  t_be;
  logic        t_gnt = 1'b0, t_rvalid = 1'b0, t_err = 1'b0;
  logic [31:0] t_rdata = 32'd0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallMemM(StallMemM), .ReadDataM(ReadDataM), .LoadValidM(LoadValidM),
    .MisalignM(MisalignM), .BusErrM(BusErrM), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
  );

  mem_lsu #(.TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallMemM(t_stall), .ReadDataM(t_rd), .LoadValidM(t_lv),
    .MisalignM(t_mis), .BusErrM(t_berr), .dmem_req(t_req),
    .dmem_we(t_we), .dmem_be(t_be), .dmem_addr(t_addr),
    .dmem_wdata(t_wdata), .dmem_gnt(t_gnt), .dmem_rvalid(t_rvalid),
    .dmem_rdata(t_rdata), .dmem_err(t_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Zero-wait transaction; returns in the DONE cycle with the access already dropped.
  task automatic zero_wait(input logic mr, input logic mw, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    tick();
    MemReadM = mr; MemWriteM = mw; funct3M = f3; ALUResultM = a; WriteDataM = wd;
    dmem_gnt = 1'b1;
    #1;
    tick();
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rd; dmem_err = 1'b0;
    tick();
    dmem_rvalid = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
    #1;
  endtask

  initial begin
    MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h100;
    WriteDataM = 32'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0;
    dmem_rdata = 32'd0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_stall", StallMemM, 1'b0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_rd", ReadDataM, 32'd0);
    chk("rst_lv", LoadValidM, 1'b0);
    chk("rst_berr", BusErrM, 1'b0);
    chk("rst_be", dmem_be, 4'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    MemReadM = 1'b0;
    reset = 1'b0;

    // LW 0x100 cycle by cycle
    tick();
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h100; dmem_gnt = 1'b1;
    #1;
    chk("lw_c0_stall", StallMemM, 1'b1);
    chk("lw_c0_req", dmem_req, 1'b0);
    tick();
    chk("lw_c1_req", dmem_req, 1'b1);
    chk("lw_c1_stall", StallMemM, 1'b1);
    chk("lw_c1_addr", dmem_addr, 32'h100);
    chk("lw_c1_we", dmem_we, 1'b0);
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_c2_req", dmem_req, 1'b0);
    chk("lw_c2_stall", StallMemM, 1'b1);
    tick();
    dmem_rvalid = 1'b0; MemReadM = 1'b0;
    #1;
    chk("lw_c3_lv", LoadValidM, 1'b1);
    chk("lw_c3_rd", ReadDataM, 32'hDEADBEEF);
    chk("lw_c3_stall", StallMemM, 1'b0);
    chk("lw_c3_berr", BusErrM, 1'b0);
    tick();
    chk("lw_c4_lv", LoadValidM, 1'b0);

    zero_wait(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80112233);
    chk("lb_rd", ReadDataM, 32'hFFFFFF80);
    zero_wait(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80112233);
    chk("lbu_rd", ReadDataM, 32'h00000080);
    zero_wait(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 32'h80112233);
    chk("lh_rd", ReadDataM, 32'hFFFF8011);
    zero_wait(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 32'h12348765);
    chk("lhu_rd", ReadDataM, 32'h00001234);
    zero_wait(1'b1, 1'b0, 3'b000, 32'h101, 32'd0, 32'h0000A500);
    chk("lb1_rd", ReadDataM, 32'hFFFFFFA5);

    zero_wait(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'd0);
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_addr", dmem_addr, 32'h200);
    chk("sh_we", dmem_we, 1'b1);
    chk("sh_lv", LoadValidM, 1'b1);
    chk("sh_rd_kept", ReadDataM, 32'hFFFFFFA5);
    zero_wait(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 32'd0);
    chk("sb_be", dmem_be, 4'b0010);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    zero_wait(1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'd0);
    chk("sw_be", dmem_be, 4'b1111);
    chk("sw_wdata", dmem_wdata, 32'hCAFEF00D);

    // Misaligned / illegal accesses never reach the bus
    tick();
    MemReadM = 1'b1; funct3M = 3'b001; ALUResultM = 32'h101;
    #1;
    chk("mis_lh", MisalignM, 1'b1);
    chk("mis_lh_stall", StallMemM, 1'b0);
    tick();
    chk("mis_lh_req", dmem_req, 1'b0);
    MemReadM = 1'b0; MemWriteM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h202;
    #1;
    chk("mis_sw", MisalignM, 1'b1);
    funct3M = 3'b100; ALUResultM = 32'h200;
    #1;
    chk("ill_sbu", MisalignM, 1'b1);
    funct3M = 3'b011;
    #1;
    chk("ill_011", MisalignM, 1'b1);
    funct3M = 3'b000;
    #1;
    chk("ok_sb", MisalignM, 1'b0);
    MemWriteM = 1'b0;
    tick();
    chk("mis_req_after", dmem_req, 1'b0);

    // Grant delayed 3 cycles, error response
    tick();
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h300; dmem_gnt = 1'b0;
    #1;
    chk("err_c0_stall", StallMemM, 1'b1);
    tick();
    chk("err_c1_req", dmem_req, 1'b1);
    tick();
    chk("err_c2_req", dmem_req, 1'b1);
    chk("err_c2_addr", dmem_addr, 32'h300);
    tick();
    chk("err_c3_req", dmem_req, 1'b1);
    dmem_gnt = 1'b1;
    #1;
    tick();
    dmem_gnt = 1'b0;
    #1;
    chk("err_c4_req", dmem_req, 1'b0);
    chk("err_c4_stall", StallMemM, 1'b1);
    dmem_rvalid = 1'b1; dmem_err = 1'b1; dmem_rdata = 32'h55555555;
    tick();
    dmem_rvalid = 1'b0; dmem_err = 1'b0; MemReadM = 1'b0;
    #1;
    chk("err_lv", LoadValidM, 1'b1);
    chk("err_berr", BusErrM, 1'b1);
    chk("err_rd", ReadDataM, 32'd0);
    tick();
    chk("err_berr_pulse", BusErrM, 1'b0);

    // Watchdog on the TIMEOUT=4 instance, no grant ever
    do_reset();
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h400;
    #1;
    chk("to_c0_stall", t_stall, 1'b1);
    tick();
    tick();
    tick();
    tick();
    chk("to_c4_req", t_req, 1'b1);
    chk("to_c4_berr", t_berr, 1'b0);
    tick();
    MemReadM = 1'b0;
    #1;
    chk("to_c5_berr", t_berr, 1'b1);
    chk("to_c5_lv", t_lv, 1'b1);
    chk("to_c5_req", t_req, 1'b0);
    chk("to_c5_rd", t_rd, 32'd0);

    // Reset while in RESP, then a late rvalid
    do_reset();
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h500; dmem_gnt = 1'b1;
    #1;
    tick();
    tick();
    dmem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    chk("rr_stall_forced", StallMemM, 1'b0);
    tick();
    reset = 1'b0; MemReadM = 1'b0;
    #1;
    chk("rr_req", dmem_req, 1'b0);
    chk("rr_stall", StallMemM, 1'b0);
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    tick();
    dmem_rvalid = 1'b0;
    #1;
    chk("rr_lv", LoadValidM, 1'b0);
    chk("rr_rd", ReadDataM, 32'd0);
    tick();
    chk("rr_lv2", LoadValidM, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage of the five-stage pipeline. It takes the executed address, store data and access size from the EX/MEM register and runs a request/grant/response transaction on the data-memory port. It aligns byte lanes, sign- or zero-extends load data, and stalls the pipeline through the hazard unit until the transaction completes. Its load result feeds the MEM/WB register.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles spent in REQ+RESP before a bus error is forced; 8-bit counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; forces IDLE and reset values
- MemReadM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage; wins if both asserted
- funct3M  in  3  access size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010)
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, right-justified
- StallMemM  out  1  hold IF..MEM while transaction outstanding
- ReadDataM  out  32  aligned, extended load data; registered
- LoadValidM  out  1  one-cycle pulse: ReadDataM valid / store acknowledged
- MisalignM  out  1  combinational fault: misaligned address or illegal funct3, no bus access
- BusErrM  out  1  one-cycle pulse with LoadValidM on dmem_err or timeout
- dmem_req  out  1  request valid, held until dmem_gnt
- dmem_we  out  1  1 = write
- dmem_be  out  4  byte enables
- dmem_addr  out  32  word address {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  response/ack valid
- dmem_rdata  in  32  read word
- dmem_err  in  1  error, sampled with dmem_rvalid

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE: an access (MemReadM|MemWriteM) that is legal and aligned latches address, funct3, we, be and wdata into dmem_* registers and moves to REQ. StallMemM is high combinationally.
- Illegal or misaligned access in IDLE: MisalignM high, no request, no stall, state stays IDLE. Misaligned means halfword with addr[0]=1 or word with addr[1:0]≠0. Illegal funct3 is 011/110/111, or 100/101 on a store.
- REQ: dmem_req=1; on dmem_gnt go to RESP, dropping dmem_req the next cycle.
- RESP: wait for dmem_rvalid, which is ignored in every other state. Go to DONE. For loads, capture extracted data; on dmem_err, set ReadDataM=0 and BusErrM.
- DONE: StallMemM=0, LoadValidM=1; return to IDLE unconditionally. The next instruction is evaluated in IDLE on the following cycle.
- Watchdog: counter clears on entering REQ and increments each cycle in REQ/RESP. Reaching TIMEOUT forces DONE with BusErrM=1 and ReadDataM=0, and drops dmem_req.
- Stores: SB be=0001<<a[1:0], wdata={4{wd[7:0]}}; SH be=0011<<a[1:0], wdata={2{wd[15:0]}}; SW be=1111.
- Loads: shift dmem_rdata right by 8*a[1:0]. Sign-extend bit 7/15 for LB/LH, zero-extend for LBU/LHU.
- Reset mid-transaction: return to IDLE, dmem_req low next edge; late rvalid is discarded.

## Timing
- Reset values: state IDLE, dmem_req/we/be/addr/wdata 0, ReadDataM 0, LoadValidM 0, BusErrM 0. StallMemM is forced 0 while reset is high.
- Zero-wait memory (gnt in the req cycle, rvalid the next cycle): access seen at cycle 0, REQ at 1, RESP at 2, DONE at 3. StallMemM is high for cycles 0–2; total latency is 4 cycles.
- Each grant wait cycle or rvalid wait cycle adds one stall cycle.
- dmem_* outputs are stable from REQ entry until the grant.

## Structure
- Package mem_lsu_pkg: lsu_state_t enum, F3_* funct3 constants, TIMEOUT default.
- Sub-module lsu_align: combinational store lane/byte-enable generation and load extraction/extension.

## Test plan
- LW addr 0x100, zero-wait memory, rdata 0xDEADBEEF -> stall cycles 0–2; LoadValidM and ReadDataM=0xDEADBEEF at cycle 3.
- LB addr 0x103, rdata 0x80112233 -> ReadDataM=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x202, WriteDataM 0x1234ABCD -> be=1100, wdata=0xABCDABCD, addr=0x200, we=1.
- LH addr 0x101 -> MisalignM=1, dmem_req never asserted, StallMemM=0.
- gnt delayed 3 cycles, rvalid with dmem_err=1 -> dmem_req held 3 cycles; BusErrM and LoadValidM pulse; ReadDataM=0.
- TIMEOUT=4, no gnt -> BusErrM at cycle 5. Separately, reset asserted in RESP -> IDLE and a later rvalid produces no LoadValidM.
